// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and the
// ticks-per-bit helper used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Integer division: the line rate is approximated by whole clock cycles per bit.
  function automatic int ticks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART serialiser; first-word-fall-through read port,
// simultaneous push and pop honoured whenever the FIFO is neither full nor empty.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  logic                 wr_ok;
  logic                 rd_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; only the pointers define validity,
  // which keeps it mappable to plain RAM/flops without a reset tree.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1, LSB first. Bytes enter through a valid/ready FIFO and
// are framed back-to-back onto the registered tx line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam int TPB = ticks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int TW  = (TPB > 1) ? $clog2(TPB) : 1;
  localparam int IW  = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TPB - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DATA_BITS - 1);

  uart_state_t          state;
  logic [TW-1:0]        bit_timer;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rd_data;
  logic                 timer_done;
  logic                 pop;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (tx_valid),
    .wr_data (tx_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign tx_ready   = !fifo_full;
  assign busy       = (state != IDLE) || !fifo_empty;
  assign timer_done = (bit_timer == TIMER_LAST);
  // A new frame starts from IDLE or straight out of a finished stop bit (no gap).
  assign pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && timer_done));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_timer <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      tx        <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx        <= 1'b1;
          bit_timer <= '0;
          if (pop) begin
            shift <= fifo_rd_data;
            tx    <= 1'b0;
            state <= START;
          end
        end

        START: begin
          if (timer_done) begin
            bit_timer <= '0;
            bit_idx   <= '0;
            tx        <= shift[0];
            state     <= DATA;
          end else begin
            bit_timer <= bit_timer + 1'b1;
          end
        end

        DATA: begin
          if (timer_done) begin
            bit_timer <= '0;
            shift     <= {1'b0, shift[DATA_BITS-1:1]};
            if (bit_idx != IDX_LAST) begin
              tx      <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end else begin
              tx    <= 1'b1;
              state <= STOP;
            end
          end else begin
            bit_timer <= bit_timer + 1'b1;
          end
        end

        STOP: begin
          if (timer_done) begin
            bit_timer <= '0;
            if (pop) begin
              shift <= fifo_rd_data;
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_timer <= bit_timer + 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          bit_timer <= '0;
          tx        <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: accepted bytes go into a scoreboard queue and
// are compared against frames decoded cycle-by-cycle from the tx line.
module tb_uart_tx;

  localparam int CLK_FREQ   = 1000;
  localparam int BAUD_RATE  = 100;
  localparam int TPB        = 10;
  localparam int DEF_TPB    = 434;
  localparam int WAIT_LIMIT = 2000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       busy;

  logic [7:0] d_tx_data;
  logic       d_tx_valid;
  logic       d_tx_ready;
  logic       d_tx;
  logic       d_busy;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  uart_tx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .busy     (busy)
  );

  uart_tx dut_def (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (d_tx_data),
    .tx_valid (d_tx_valid),
    .tx_ready (d_tx_ready),
    .tx       (d_tx),
    .busy     (d_busy)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && tx_valid && tx_ready) sb.push_back(tx_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [7:0] b, output int waited);
    tx_data  = b;
    tx_valid = 1'b1;
    waited   = 0;
    while (tx_ready !== 1'b1 && waited < WAIT_LIMIT) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= WAIT_LIMIT) check("send_timeout", tx_ready, 1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Waits for a start bit, then samples every cycle of the 10-bit frame.
  task automatic rx_frame(output logic [7:0] data, output int t_start);
    int         n = 0;
    int         unstable = 0;
    logic [9:0] slot_val;
    logic       v;
    while (tx !== 1'b0 && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    t_start = cyc;
    if (tx !== 1'b0) begin
      check("rx_start_timeout", tx, 0);
      data = 'x;
      return;
    end
    for (int s = 0; s < 10; s++) begin
      v = tx;
      slot_val[s] = v;
      for (int c = 0; c < TPB; c++) begin
        if (tx !== v) unstable++;
        @(negedge clk);
      end
    end
    check("rx_start_bit", slot_val[0], 0);
    check("rx_stop_bit", slot_val[9], 1);
    check("rx_bit_stable", unstable, 0);
    data = slot_val[8:1];
  endtask

  task automatic rx_expect(input string tag, output int t_start);
    logic [7:0] got;
    logic [7:0] exp;
    rx_frame(got, t_start);
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 0, 1);
    end else begin
      exp = sb.pop_front();
      check(tag, got, exp);
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : main
    int w, w_sum, acc, guard, mism, n;
    int t_a, t_b, t_prev;
    logic       r;
    logic       last_busy;
    logic [9:0] frame;

    rst_n      = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    d_tx_valid = 1'b0;
    d_tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_ready", tx_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_def_tx", d_tx, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single byte, latency and framing
    send(8'hA5, w);
    check("t1_tx_high_after_accept", tx, 1);
    check("t1_busy_after_accept", busy, 1);
    @(negedge clk);
    check("t1_tx_low_next_edge", tx, 0);
    rx_expect("t1_data", t_a);
    check("t1_busy_end", busy, 0);

    // 2: burst of five, sixth held off, back-to-back frames
    fork
      begin
        w_sum = 0;
        for (int b = 1; b <= 5; b++) begin
          send(8'(b), w);
          w_sum += w;
        end
        check("t2_first5_no_wait", w_sum, 0);
        check("t2_ready_full", tx_ready, 0);
        send(8'h06, w);
        check("t2_hold_cycles", w, 10*TPB - 3);
      end
      begin
        for (int i = 0; i < 6; i++) begin
          rx_expect("t2_data", t_b);
          if (i > 0) check("t2_gap", t_b - t_prev, 10*TPB);
          t_prev = t_b;
        end
      end
    join
    check("t2_busy_end", busy, 0);

    // 3: valid held with changing data while stalled
    fork
      begin
        tx_valid = 1'b1;
        acc = 0;
        guard = 0;
        while (acc < 8 && guard < 4*WAIT_LIMIT) begin
          tx_data = 8'($urandom);
          r = tx_ready;
          @(negedge clk);
          if (r) acc++;
          guard++;
        end
        tx_valid = 1'b0;
        check("t3_accepted", acc, 8);
      end
      begin
        for (int i = 0; i < 8; i++) rx_expect("t3_data", t_b);
      end
    join
    check("t3_sb_empty", sb.size(), 0);

    // 4: reset during data bit 3
    send(8'hFF, w);
    n = 0;
    while (tx !== 1'b0 && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("t4_start_seen", tx, 0);
    repeat (45) @(negedge clk);
    check("t4_busy_midframe", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t4_reset_tx", tx, 1);
    check("t4_reset_busy", busy, 0);
    check("t4_reset_ready", tx_ready, 1);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mism = 0;
    for (int i = 0; i < 3*TPB; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) mism++;
    end
    check("t4_no_remnant", mism, 0);
    fork
      send(8'h3C, w);
      rx_expect("t4_data", t_b);
    join

    // 5: write coinciding with the stop-bit pop
    fork
      begin
        send(8'h11, w);
        send(8'h22, w);
        repeat (10*TPB - 1) @(negedge clk);
        send(8'h33, w);
        check("t5_fifo_count", dut.u_fifo.count, 1);
      end
      begin
        rx_expect("t5_data_a", t_a);
        rx_expect("t5_data_b", t_b);
        check("t5_gap_ab", t_b - t_a, 10*TPB);
        t_prev = t_b;
        rx_expect("t5_data_c", t_b);
        check("t5_gap_bc", t_b - t_prev, 10*TPB);
      end
    join
    check("t5_busy_end", busy, 0);

    // 6: default parameters, 434 cycles per bit
    d_tx_data  = 8'h55;
    d_tx_valid = 1'b1;
    @(negedge clk);
    d_tx_valid = 1'b0;
    n = 0;
    while (d_tx !== 1'b0 && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("t6_start_seen", d_tx, 0);
    frame = {1'b1, 8'h55, 1'b0};
    mism = 0;
    last_busy = 1'b0;
    for (int i = 0; i < 10*DEF_TPB; i++) begin
      if (d_tx !== frame[i / DEF_TPB]) mism++;
      if (i == 10*DEF_TPB - 1) last_busy = d_busy;
      @(negedge clk);
    end
    check("t6_bit_timing", mism, 0);
    check("t6_busy_last_cycle", last_busy, 1);
    check("t6_busy_after_frame", d_busy, 0);
    check("t6_tx_idle", d_tx, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter, 8N1, LSB first; the transmit counterpart of the existing UART receiver.
- Takes bytes over a valid/ready handshake into a small internal FIFO.
- Serialises them onto the tx line with back-to-back framing.
- Sits between the systolic-array result path (host readback) and the board UART pin.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz
- BAUD_RATE, 115200, line rate in bits/s; TICKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division, must be >= 2)
- FIFO_DEPTH, 4, byte FIFO entries; power of two, >= 2

Ports:
- clk  input  1  system clock, all logic on posedge
- rst_n  input  1  asynchronous active-low reset
- tx_data  input  8  byte to send
- tx_valid  input  1  tx_data valid this cycle
- tx_ready  output  1  FIFO can accept a byte this cycle
- tx  output  1  serial line, idle high, registered
- busy  output  1  high while FIFO non-empty or a frame is in progress

Behaviour:
- Reset (async, rst_n low): tx=1, tx_ready=1, busy=0, FIFO emptied, FSM in IDLE, counters 0. Assertion mid-frame aborts the frame immediately; the line returns high and no partial byte is retried.
- Handshake:
  - A byte is accepted on a posedge where tx_valid && tx_ready.
  - tx_ready = !fifo_full, combinational from FIFO state.
  - tx_data may change freely when not accepted.
  - tx_valid while tx_ready=0 is ignored; no overwrite.
  - A write while full is impossible by construction.
  - A simultaneous write and pop on a non-full FIFO are both honoured, and the count is unchanged.
- FSM states: IDLE, START, DATA, STOP; bit_timer counts 0..TICKS_PER_BIT-1; bit_idx 0..7; shift register 8 bits.
  - IDLE: tx=1. If the FIFO is non-empty: pop the head into the shift register, drive tx=0, clear bit_timer, go to START.
  - START: hold tx=0 for exactly TICKS_PER_BIT cycles. On bit_timer==TICKS_PER_BIT-1: drive tx=shift[0], set bit_idx=0, go to DATA.
  - DATA: each bit is held TICKS_PER_BIT cycles. At the end of a bit: shift right. If bit_idx<7, output the next bit and increment bit_idx; else drive tx=1 and go to STOP.
  - STOP: hold tx=1 for TICKS_PER_BIT cycles. At the end: if the FIFO is non-empty, pop, drive tx=0 and go to START (zero idle gap); else go to IDLE.
- Frame length: exactly 10*TICKS_PER_BIT cycles from tx falling to the end of the stop bit.
- Latency: a byte accepted at edge k into an empty FIFO with the FSM in IDLE: the FIFO is non-empty after edge k, and tx goes low after edge k+1.
- busy = (state != IDLE) || !fifo_empty, combinational.
- Bytes are transmitted in acceptance order. With FIFO_DEPTH=4, up to 4 queued plus 1 in the shift register.
- bit_timer is wide enough for TICKS_PER_BIT-1 ($clog2). No overflow/wrap beyond the terminal count.
- Illegal state encoding returns to IDLE with tx=1.

Decomposition:
- Shared package uart_pkg:
  - FSM state encodings (IDLE/START/DATA/STOP), shared with the receiver's naming
  - frame constants DATA_BITS=8, STOP_BITS=1
  - ticks-per-bit calculation as a constant function of CLK_FREQ and BAUD_RATE
- One sub-module, uart_tx_fifo:
  - synchronous FIFO with async active-low reset, parameter DEPTH, width 8
  - ports: wr_en/wr_data, rd_en/rd_data (first-word-fall-through), full, empty

Test Plan:
All scenarios use CLK_FREQ=1000, BAUD_RATE=100 (TICKS_PER_BIT=10) unless noted.
1. Single byte 0xA5 accepted at edge k -> tx low from edge k+1 for 10 cycles. Then data bits 1,0,1,0,0,1,0,1 (LSB first), 10 cycles each. Then stop high for 10 cycles. busy falls after the stop bit; loopback into uart_rx yields data_out=0xA5.
2. Burst: write 0x01,0x02,0x03,0x04,0x05 on consecutive cycles:
   - first 5 accepted (1 popped immediately, 4 queued)
   - tx_ready=0 once 4 entries are held
   - the 6th write is held off until tx_ready rises
   - frames are back-to-back with no idle gap: each start bit follows its predecessor's stop bit directly, 100 cycles per frame
3. tx_valid held high with tx_ready=0 and changing tx_data -> no byte lost or duplicated; received sequence equals the accepted sequence.
4. rst_n asserted during data bit 3 of 0xFF -> tx=1 immediately (async), busy=0, tx_ready=1. After release, a new byte 0x3C transmits correctly with no remnants of 0xFF.
5. Simultaneous event: FIFO holds 1 entry and the FSM pops at the end of STOP on the same edge a new byte is written -> both occur, count stays 1, and ordering is preserved.
6. Default parameters (TICKS_PER_BIT=434): send 0x55 -> each bit lasts exactly 434 cycles and the frame lasts 4340 cycles.
